// File: rtl/input_preprocess_pkg.sv
// ---------------------------------------------------------------------------
// input_pkg
// Shared constants for the input preprocessing slice.
//   - Source indices: the index of a source is also its arbitration rank,
//     index 0 (reset_table) wins over every other source.
//   - Switch bit positions inside SW.
//   - Debounce cell state encoding and the fixed-priority grant helper.
// ---------------------------------------------------------------------------
package input_pkg;

    localparam int unsigned NUM_SRC = 6;

    // Priority order, highest first.
    localparam int unsigned SRC_RESET_TABLE   = 0;
    localparam int unsigned SRC_START_GAME    = 1;
    localparam int unsigned SRC_DONE_AND_NEXT = 2;
    localparam int unsigned SRC_DRAW_AND_NEXT = 3;
    localparam int unsigned SRC_MOVE_LEFT     = 4;
    localparam int unsigned SRC_MOVE_RIGHT    = 5;

    localparam int unsigned SW_WIDTH       = 16;
    localparam int unsigned SW_START       = 0;
    localparam int unsigned SW_RESET_TABLE = 1;
    localparam int unsigned SW_DONE        = 2;
    localparam int unsigned SW_DRAW        = 3;

    typedef enum logic {
        CELL_ARM,
        CELL_STABLE
    } cell_state_e;

    // Isolate the lowest set bit, which is the highest-priority request.
    function automatic logic [NUM_SRC-1:0] grant_highest(input logic [NUM_SRC-1:0] req);
        return req & (~req + NUM_SRC'(1));
    endfunction

endpackage

// File: rtl/input_preprocess_if.sv
// ---------------------------------------------------------------------------
// input_preprocess_if
// Board-side bundle: raw buttons/switches in, game command pulses out.
//   master : the board / stimulus side (drives btnL, btnR, SW)
//   slave  : the preprocessor (consumes raw inputs, drives command pulses)
// ---------------------------------------------------------------------------
interface input_preprocess_if
    import input_pkg::*;
();
    logic                btnL;
    logic                btnR;
    logic [SW_WIDTH-1:0] SW;
    logic                move_left;
    logic                move_right;
    logic                start_game;
    logic                reset_table;
    logic                done_and_next;
    logic                draw_and_next;

    modport master (
        output btnL, btnR, SW,
        input  move_left, move_right, start_game, reset_table, done_and_next, draw_and_next
    );

    modport slave (
        input  btnL, btnR, SW,
        output move_left, move_right, start_game, reset_table, done_and_next, draw_and_next
    );
endinterface

// File: rtl/input_preprocess_debounce_cell.sv
// ---------------------------------------------------------------------------
// debounce_cell
// 2-flop synchroniser + debounce counter + ARM/STABLE FSM for one raw input.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr_i     : synchronous clear (back to ARM, counter cleared)
//   raw_i     : raw asynchronous input
//   rise_o    : one-cycle pulse when the accepted level rises in STABLE
//   level_o   : accepted (debounced) level
// ARM adopts the first level held for CYCLES cycles as baseline without
// producing an event, so an input already high at reset never fires.
// ---------------------------------------------------------------------------
module debounce_cell
    import input_pkg::*;
#(
    parameter int unsigned CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic raw_i,
    output logic rise_o,
    output logic level_o
);
    localparam int unsigned     CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0]   LAST = CW'(CYCLES - 1);

    logic          sync1_q, sync2_q;
    cell_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= CELL_ARM;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        if (clr_i) begin
            state_d = CELL_ARM;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                CELL_ARM: begin
                    // Follow the input silently; go live once it has held still.
                    if (sync2_q != level_q) begin
                        level_d = sync2_q;
                        cnt_d   = '0;
                    end else if (cnt_q == LAST) begin
                        state_d = CELL_STABLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                CELL_STABLE: begin
                    if (sync2_q == level_q) begin
                        cnt_d = '0;
                    end else if (cnt_q == LAST) begin
                        level_d = sync2_q;
                        cnt_d   = '0;
                        rise_d  = sync2_q;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = CELL_ARM;
            endcase
        end
    end

    assign rise_o  = rise_q;
    assign level_o = level_q;

endmodule

// File: rtl/input_preprocess.sv
// ---------------------------------------------------------------------------
// input_preprocess
// Turns raw buttons/switches into single-cycle game command pulses, at most
// one pulse high per cycle.
// Ports:
//   clk            : system clock
//   rst            : asynchronous reset, active-high
//   interboard_rst : synchronous game reset from the partner board
//   bus (slave)    : btnL, btnR, SW in; move_left, move_right, start_game,
//                    reset_table, done_and_next, draw_and_next out
// Optional feature: define INPUT_PREPROCESS_AUTO_REPEAT_EN to auto-repeat
// held buttons (REPEAT_DELAY after the press, then every REPEAT_PERIOD).
// ---------------------------------------------------------------------------
module input_preprocess
    import input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
`ifdef INPUT_PREPROCESS_AUTO_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 20_000_000
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               interboard_rst,
    input_preprocess_if.slave  bus
);
    logic [NUM_SRC-1:0] raw, rise, level, rep_evt, evt, eff, grant;
    logic [NUM_SRC-1:0] pend_q, pend_d, out_q, out_d;

    assign raw[SRC_RESET_TABLE]   = bus.SW[SW_RESET_TABLE];
    assign raw[SRC_START_GAME]    = bus.SW[SW_START];
    assign raw[SRC_DONE_AND_NEXT] = bus.SW[SW_DONE];
    assign raw[SRC_DRAW_AND_NEXT] = bus.SW[SW_DRAW];
    assign raw[SRC_MOVE_LEFT]     = bus.btnL;
    assign raw[SRC_MOVE_RIGHT]    = bus.btnR;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_cell
        debounce_cell #(.CYCLES(DEBOUNCE_CYCLES)) u_cell (
            .clk     (clk),
            .rst     (rst),
            .clr_i   (interboard_rst),
            .raw_i   (raw[g]),
            .rise_o  (rise[g]),
            .level_o (level[g])
        );
    end

`ifdef INPUT_PREPROCESS_AUTO_REPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    assign rep_evt[SRC_DRAW_AND_NEXT:SRC_RESET_TABLE] = '0;

    // Buttons occupy the two top source indices.
    for (genvar b = 0; b < 2; b++) begin : g_rep
        localparam int unsigned SRC = SRC_MOVE_LEFT + b;
        logic          act_q, act_d, per_q, per_d, fire;
        logic [RW-1:0] cnt_q, cnt_d;

        // Counting starts the cycle the press pulse is registered, so a
        // fire seen here becomes an output pulse exactly DELAY/PERIOD later.
        assign fire         = act_q && (cnt_q == (per_q ? PER_LAST : DLY_LAST));
        assign rep_evt[SRC] = fire;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                act_q <= 1'b0;
                per_q <= 1'b0;
                cnt_q <= '0;
            end else begin
                act_q <= act_d;
                per_q <= per_d;
                cnt_q <= cnt_d;
            end
        end

        always_comb begin
            act_d = act_q;
            per_d = per_q;
            cnt_d = cnt_q;
            if (interboard_rst || !level[SRC]) begin
                act_d = 1'b0;
                per_d = 1'b0;
                cnt_d = '0;
            end else if (rise[SRC]) begin
                act_d = 1'b1;
                per_d = 1'b0;
                cnt_d = '0;
            end else if (fire) begin
                per_d = 1'b1;
                cnt_d = '0;
            end else if (act_q) begin
                cnt_d = cnt_q + RW'(1);
            end
        end
    end
`else
    assign rep_evt = '0;
`endif

    // Events only count while the accepted level is high.
    assign evt   = (rise | rep_evt) & level;
    assign eff   = pend_q | evt;
    assign grant = grant_highest(eff);

    always_comb begin
        pend_d = eff & ~grant;
        out_d  = grant;
        if (interboard_rst) begin
            pend_d = '0;
            out_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            out_q  <= '0;
        end else begin
            pend_q <= pend_d;
            out_q  <= out_d;
        end
    end

    assign bus.reset_table   = out_q[SRC_RESET_TABLE];
    assign bus.start_game    = out_q[SRC_START_GAME];
    assign bus.done_and_next = out_q[SRC_DONE_AND_NEXT];
    assign bus.draw_and_next = out_q[SRC_DRAW_AND_NEXT];
    assign bus.move_left     = out_q[SRC_MOVE_LEFT];
    assign bus.move_right    = out_q[SRC_MOVE_RIGHT];

endmodule

// File: tb/tb_input_preprocess.sv
// ---------------------------------------------------------------------------
// tb_input_preprocess
// Scoreboard bench for input_preprocess with DEBOUNCE_CYCLES=4 (and
// REPEAT_DELAY=20, REPEAT_PERIOD=8 when INPUT_PREPROCESS_AUTO_REPEAT_EN).
// A raw edge driven after posedge c is expected as an output pulse visible
// after posedge c+7: 2 sync + 4 debounce + 1 output register.
// ---------------------------------------------------------------------------
module tb_input_preprocess;
    import input_pkg::*;

    localparam int unsigned LAT = 7;

    typedef struct {
        logic [NUM_SRC-1:0] code;
        int unsigned        cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        interboard_rst = 1'b0;
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    exp_t        sb[$];
    logic [NUM_SRC-1:0] obs;

    input_preprocess_if bus ();

    input_preprocess #(
        .DEBOUNCE_CYCLES (4)
`ifdef INPUT_PREPROCESS_AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8)
`endif
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .interboard_rst (interboard_rst),
        .bus            (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign obs = {bus.move_right, bus.move_left, bus.draw_and_next,
                  bus.done_and_next, bus.start_game, bus.reset_table};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [NUM_SRC-1:0] src_bit(input int unsigned s);
        return NUM_SRC'(1) << s;
    endfunction

    task automatic expect_pulse(input int unsigned s, input int unsigned at);
        exp_t e;
        e.code = src_bit(s);
        e.cyc  = at;
        sb.push_back(e);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Every nonzero output cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && obs != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'(obs), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_code", 32'(obs), 32'(e.code));
                check("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int unsigned c;
        bus.btnL = 1'b0;
        bus.btnR = 1'b0;
        bus.SW   = '0;
        bus.SW[SW_START] = 1'b1;          // already up at reset: must never fire

        idle(3);
        check("reset_outputs", 32'(obs), 32'd0);
        rst = 1'b0;
        idle(20);

        // Clean press held 10 cycles: one pulse, nothing on release.
        c = cyc;
        bus.btnL = 1'b1;
        expect_pulse(SRC_MOVE_LEFT, c + LAT);
        idle(10);
        bus.btnL = 1'b0;
        idle(20);

        // 3-cycle glitch: shorter than the debounce window, no pulse.
        bus.btnR = 1'b1;
        idle(3);
        bus.btnR = 1'b0;
        idle(20);

        // SW[0] toggled down then up, each held 6 cycles: one start pulse.
        bus.SW[SW_START] = 1'b0;
        idle(6);
        c = cyc;
        bus.SW[SW_START] = 1'b1;
        expect_pulse(SRC_START_GAME, c + LAT);
        idle(20);

        // Simultaneous rises are serialised in priority order.
        c = cyc;
        bus.SW[SW_RESET_TABLE] = 1'b1;
        bus.SW[SW_DONE]        = 1'b1;
        bus.btnL               = 1'b1;
        expect_pulse(SRC_RESET_TABLE,   c + LAT);
        expect_pulse(SRC_DONE_AND_NEXT, c + LAT + 1);
        expect_pulse(SRC_MOVE_LEFT,     c + LAT + 2);
        idle(10);
        bus.btnL = 1'b0;
        bus.SW   = '0;
        idle(20);

        // interboard_rst while start/draw are still pending drops them.
        c = cyc;
        bus.SW[SW_START]       = 1'b1;
        bus.SW[SW_RESET_TABLE] = 1'b1;
        bus.SW[SW_DRAW]        = 1'b1;
        expect_pulse(SRC_RESET_TABLE, c + LAT);
        idle(LAT);
        interboard_rst = 1'b1;
        @(negedge clk);
        interboard_rst = 1'b0;
        check("ibrst_outputs_zero", 32'(obs), 32'd0);
        idle(20);
        check("ibrst_idle", 32'(obs), 32'd0);

`ifdef INPUT_PREPROCESS_AUTO_REPEAT_EN
        // Held button auto-repeats; release stops it.
        c = cyc;
        bus.btnR = 1'b1;
        expect_pulse(SRC_MOVE_RIGHT, c + LAT);
        expect_pulse(SRC_MOVE_RIGHT, c + LAT + 20);
        expect_pulse(SRC_MOVE_RIGHT, c + LAT + 28);
        expect_pulse(SRC_MOVE_RIGHT, c + LAT + 36);
        expect_pulse(SRC_MOVE_RIGHT, c + LAT + 44);
        idle(50);
        bus.btnR = 1'b0;
        idle(40);
`endif

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
